// File: rtl/int_square_calculator.sv
// int_square_calculator
// Multi-cycle unsigned squarer. It forms X*X by adding the first X odd numbers,
// one addition per clock. This is the same odd-step method the square-root unit
// uses, so the two blocks can check each other in a round trip.
// Latency from the accepting edge to a valid sq/done is X+2 cycles.

module int_square_calculator #(
  parameter int W = 8
) (
  input  logic           CLK,
  input  logic           RESET,
  input  logic           S,
  input  logic [W-1:0]   X,
  output logic [2*W-1:0] sq,
  output logic           done,
  output logic           busy
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ACC  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   cnt_q,   cnt_d;
  logic [W:0]     odd_q,   odd_d;
  logic [2*W-1:0] acc_q,   acc_d;
  logic [2*W-1:0] sq_q,    sq_d;
  logic           done_q,  done_d;
  logic           busy_q,  busy_d;

  // Widen the odd term to the accumulator width. The odd term never exceeds
  // 2^(W+1)-1 and the final sum is at most (2^W-1)^2, so no wrap logic is needed.
  logic [2*W-1:0] odd_ext_s;
  assign odd_ext_s = (2*W)'(odd_q);

  // Next-state and datapath: hold by default, then update according to state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    odd_d   = odd_q;
    acc_d   = acc_q;
    sq_d    = sq_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (S) begin
          cnt_d   = X;
          odd_d   = (W+1)'(1);
          acc_d   = (2*W)'(0);
          state_d = ACC;
        end else begin
          state_d = IDLE;
        end
      end
      ACC: begin
        if (cnt_q != W'(0)) begin
          acc_d   = acc_q + odd_ext_s;
          odd_d   = odd_q + (W+1)'(2);
          cnt_d   = cnt_q - W'(1);
          state_d = ACC;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        sq_d    = acc_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // busy is registered so that it tracks the state register exactly.
    busy_d = (state_d != IDLE);
  end

  // State and datapath registers with asynchronous active-high reset.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= W'(0);
      odd_q   <= (W+1)'(1);
      acc_q   <= (2*W)'(0);
      sq_q    <= (2*W)'(0);
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      odd_q   <= odd_d;
      acc_q   <= acc_d;
      sq_q    <= sq_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign sq   = sq_q;
  assign done = done_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_int_square_calculator.sv
// Self-checking bench for int_square_calculator (W=8).
// Reference model: sq = X*X, latency X+2 edges, and isqrt(sq) == X.
`timescale 1ns/1ps

module tb_int_square_calculator;

  logic        CLK;
  logic        RESET;
  logic        S;
  logic [7:0]  X;
  logic [15:0] sq;
  logic        done;
  logic        busy;

  int checks = 0;
  int errors = 0;

  int_square_calculator #(.W(8)) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .S    (S),
    .X    (X),
    .sq   (sq),
    .done (done),
    .busy (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Single comparison point for every check in this bench.
  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Integer square root computed by plain search (the companion unit's function).
  function automatic int isqrt(input int v);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  // Start one operation, wait for done, and check result, latency and the done pulse.
  task automatic run_op(input logic [7:0] x);
    int   lat;
    logic busy_ok;
    int   exp_sq;
    exp_sq = int'(x) * int'(x);
    @(negedge CLK);
    S = 1'b1;
    X = x;
    @(posedge CLK);
    #1;
    S = 1'b0;
    X = 8'($urandom);
    lat = 0;
    busy_ok = 1'b1;
    while (!done && lat < 300) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(posedge CLK);
      #1;
      lat++;
    end
    check_val("done_seen", 32'(done), 32'd1);
    check_val("latency", 32'(lat), 32'(int'(x) + 2));
    check_val("sq", 32'(sq), 32'(exp_sq));
    check_val("busy_while_running", 32'(busy_ok), 32'd1);
    check_val("busy_low_at_done", 32'(busy), 32'd0);
    check_val("round_trip_isqrt", 32'(isqrt(int'(sq))), 32'(x));
    @(posedge CLK);
    #1;
    check_val("done_one_cycle", 32'(done), 32'd0);
    check_val("sq_hold", 32'(sq), 32'(exp_sq));
  endtask

  // Insert a run of idle cycles with S low.
  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      S = 1'b0;
    end
  endtask

  initial begin
    int   lat;
    logic saw_done;

    RESET = 1'b1;
    S     = 1'b0;
    X     = 8'd0;
    #12;
    check_val("reset_sq", 32'(sq), 32'd0);
    check_val("reset_done", 32'(done), 32'd0);
    check_val("reset_busy", 32'(busy), 32'd0);
    @(negedge CLK);
    RESET = 1'b0;
    @(posedge CLK);
    #1;
    check_val("post_reset_busy", 32'(busy), 32'd0);

    // Directed cases: zero, mid value, maximum operand.
    run_op(8'd0);
    run_op(8'd12);
    idle_gap(4);
    check_val("sq_hold_idle", 32'(sq), 32'd144);
    run_op(8'd255);

    // Back-to-back: S held high, X changed while busy.
    @(negedge CLK);
    S = 1'b1;
    X = 8'd5;
    @(posedge CLK);
    #1;
    X = 8'd200;
    lat = 0;
    while (!done && lat < 300) begin
      @(posedge CLK);
      #1;
      lat++;
    end
    check_val("b2b_first_latency", 32'(lat), 32'd7);
    check_val("b2b_first_sq", 32'(sq), 32'd25);
    @(posedge CLK);
    #1;
    lat++;
    check_val("b2b_second_accepted", 32'(busy), 32'd1);
    check_val("b2b_sq_holds", 32'(sq), 32'd25);
    S = 1'b0;
    while (!done && lat < 500) begin
      @(posedge CLK);
      #1;
      lat++;
    end
    check_val("b2b_second_latency", 32'(lat), 32'd210);
    check_val("b2b_second_sq", 32'(sq), 32'd40000);

    // Reset in the middle of an accumulation.
    @(negedge CLK);
    S = 1'b1;
    X = 8'd100;
    @(posedge CLK);
    #1;
    S = 1'b0;
    for (int i = 0; i < 39; i++) @(posedge CLK);
    #1;
    check_val("mid_acc_busy", 32'(busy), 32'd1);
    #2;
    RESET = 1'b1;
    #1;
    check_val("async_reset_sq", 32'(sq), 32'd0);
    check_val("async_reset_busy", 32'(busy), 32'd0);
    check_val("async_reset_done", 32'(done), 32'd0);
    @(negedge CLK);
    RESET = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 110; i++) begin
      @(posedge CLK);
      #1;
      if (done) saw_done = 1'b1;
    end
    check_val("no_done_after_abort", 32'(saw_done), 32'd0);
    check_val("idle_after_abort", 32'(busy), 32'd0);
    run_op(8'd3);

    // Sweep every operand with random idle gaps.
    for (int v = 0; v < 256; v++) begin
      idle_gap(int'($urandom_range(0, 3)));
      run_op(8'(v));
    end

    // A few random operands in random order.
    for (int i = 0; i < 16; i++) begin
      idle_gap(int'($urandom_range(0, 2)));
      run_op(8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
